fd_pipe_reg: RTL and testbench



---
 rtl/fd_pipe_reg_if.sv | 25 ++
 rtl/fd_pipe_reg.sv | 83 ++++++++
 tb/tb_fd_pipe_reg.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/fd_pipe_reg_if.sv
// F->D pipeline register bus: fetch-side inputs, hazard/CP0 controls and the
// latched D-stage entry. slave = the register itself, master = its environment.
interface fd_pipe_reg_if;
  logic [31:0] instr_f;
  logic [31:0] pc_f;
  logic        stall;
  logic        exc_flush;
  logic        jump_d;
  logic        eret_d;
  logic [31:0] instr_d;
  logic [31:0] pc_d;
  logic [4:0]  exccode_d;
  logic        bd_d;
  logic        valid_d;

  modport master (
    output instr_f, pc_f, stall, exc_flush, jump_d, eret_d,
    input  instr_d, pc_d, exccode_d, bd_d, valid_d
  );

  modport slave (
    input  instr_f, pc_f, stall, exc_flush, jump_d, eret_d,
    output instr_d, pc_d, exccode_d, bd_d, valid_d
  );
endinterface

// File: rtl/fd_pipe_reg.sv
// Fetch/decode pipeline register with AdEL tagging, delay-slot flag and
// flush/stall/eret-annul resolution. Define FD_ADDR_CHECK_EN to enable AdEL checks.
module fd_pipe_reg #(
  parameter logic [31:0] TEXT_BASE = 32'h0000_3000,
  parameter logic [31:0] TEXT_TOP  = 32'h0000_6FFC,
  parameter logic [31:0] BUBBLE_PC = 32'h0000_0000
) (
  input logic           clk,
  input logic           reset,
  fd_pipe_reg_if.slave  bus
);

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [4:0]  exccode;
    logic        bd;
    logic        valid;
  } fd_entry_t;

  localparam logic [4:0] EXC_NONE = 5'd0;
  localparam logic [4:0] EXC_ADEL = 5'd4;

`ifdef FD_ADDR_CHECK_EN
  localparam logic ADDR_CHK_EN = 1'b1;
`else
  localparam logic ADDR_CHK_EN = 1'b0;
`endif

  localparam fd_entry_t BUBBLE = '{
    instr:   32'd0,
    pc:      BUBBLE_PC,
    exccode: EXC_NONE,
    bd:      1'b0,
    valid:   1'b0
  };

  fd_entry_t entry_q;
  fd_entry_t load_val;
  logic      annul_pend;
  logic      misalign, below, above, fault_f;

  // Unsigned 32-bit bounds; no PC arithmetic, so 0xFFFF_FFFC is simply out of range.
  assign misalign = |bus.pc_f[1:0];
  assign below    = bus.pc_f < TEXT_BASE;
  assign above    = bus.pc_f > TEXT_TOP;
  assign fault_f  = ADDR_CHK_EN & (misalign | below | above);

  always_comb begin
    load_val         = BUBBLE;
    load_val.instr   = fault_f ? 32'd0 : bus.instr_f;
    load_val.pc      = bus.pc_f;
    load_val.exccode = fault_f ? EXC_ADEL : EXC_NONE;
    load_val.bd      = bus.jump_d;
    load_val.valid   = 1'b1;
  end

  // annul_pend remembers an eret that sat in D under stall, so its PC+4
  // fetch is still annulled on the first edge that actually moves.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      entry_q    <= BUBBLE;
      annul_pend <= 1'b0;
    end else if (bus.exc_flush) begin
      entry_q    <= BUBBLE;
      annul_pend <= 1'b0;
    end else if (bus.stall) begin
      if (bus.eret_d) annul_pend <= 1'b1;
    end else if (bus.eret_d || annul_pend) begin
      entry_q    <= BUBBLE;
      annul_pend <= 1'b0;
    end else begin
      entry_q    <= load_val;
    end
  end

  assign bus.instr_d   = entry_q.instr;
  assign bus.pc_d      = entry_q.pc;
  assign bus.exccode_d = entry_q.exccode;
  assign bus.bd_d      = entry_q.bd;
  assign bus.valid_d   = entry_q.valid;

endmodule

// File: tb/tb_fd_pipe_reg.sv
// Scoreboard bench for fd_pipe_reg: directed plan items plus random traffic
// against a rule-level reference model; honours FD_ADDR_CHECK_EN.
module tb_fd_pipe_reg;
  localparam logic [31:0] BASE = 32'h0000_3000;
  localparam logic [31:0] TOP  = 32'h0000_6FFC;
  localparam logic [31:0] BPC  = 32'h0000_0000;

  logic clk;
  logic reset;
  fd_pipe_reg_if bus();

  fd_pipe_reg #(.TEXT_BASE(BASE), .TEXT_TOP(TOP), .BUBBLE_PC(BPC)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {instr, pc, exccode, bd, valid}
  typedef logic [70:0] ent_t;

  ent_t exp_q[$];
  int   errors = 0;
  int   checks = 0;

  // reference model state: what D holds, and whether an annul is owed
  ent_t m_d;
  bit   m_owe_annul;

  function automatic ent_t mk(logic [31:0] i, logic [31:0] p, logic [4:0] e, logic b, logic v);
    return {i, p, e, b, v};
  endfunction

  function automatic ent_t bubble();
    return mk(32'd0, BPC, 5'd0, 1'b0, 1'b0);
  endfunction

  function automatic bit bad_addr(logic [31:0] p);
`ifdef FD_ADDR_CHECK_EN
    return (p % 4 != 0) || (p < BASE) || (p > TOP);
`else
    return 1'b0;
`endif
  endfunction

  function automatic ent_t dut_ent();
    return {bus.instr_d, bus.pc_d, bus.exccode_d, bus.bd_d, bus.valid_d};
  endfunction

  task automatic check(string name, ent_t act, ent_t req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got instr=%h pc=%h exc=%0d bd=%b v=%b, want instr=%h pc=%h exc=%0d bd=%b v=%b",
               name, act[70:39], act[38:7], act[6:2], act[1], act[0],
               req[70:39], req[38:7], req[6:2], req[1], req[0]);
    end
  endtask

  // Called at a negedge: drive one cycle's inputs, predict D after the edge.
  task automatic step(logic [31:0] instr, logic [31:0] pc, bit st, bit fl, bit jmp, bit er);
    bit f;
    bus.instr_f = instr; bus.pc_f = pc; bus.stall = st;
    bus.exc_flush = fl; bus.jump_d = jmp; bus.eret_d = er;
    f = bad_addr(pc);
    if (fl) begin
      m_d = bubble(); m_owe_annul = 0;
    end else if (st) begin
      if (er) m_owe_annul = 1;
    end else if (er || m_owe_annul) begin
      m_d = bubble(); m_owe_annul = 0;
    end else begin
      m_d = mk(f ? 32'd0 : instr, pc, f ? 5'd4 : 5'd0, jmp, 1'b1);
    end
    exp_q.push_back(m_d);
    @(negedge clk);
  endtask

  // Called at a negedge: async reset between edges, checked before any edge.
  task automatic async_reset();
    #2 reset = 1'b0;
    #1 check("async_reset", dut_ent(), bubble());
    m_d = bubble(); m_owe_annul = 0;
    @(negedge clk);
    reset = 1'b1;
  endtask

  // monitor: one scoreboard entry per edge that stimulus predicted
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() != 0) check("d_entry", dut_ent(), exp_q.pop_front());
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] pc, ins;
    int sel;
    reset = 1'b0;
    bus.instr_f = 32'hDEAD_BEEF; bus.pc_f = 32'h3000; bus.stall = 0;
    bus.exc_flush = 0; bus.jump_d = 0; bus.eret_d = 0;
    m_d = bubble(); m_owe_annul = 0;
    repeat (2) @(negedge clk);
    check("reset_state", dut_ent(), bubble());
    bus.stall = 1;  // reset released mid-stall: first edge must hold the bubble
    reset = 1'b1;
    step(32'h1111_1111, 32'h3004, 1, 0, 0, 0);

    // normal, misaligned, out-of-range, wrap-around
    step(32'h3401_0005, 32'h3000, 0, 0, 0, 0);
    step(32'h2222_2222, 32'h3002, 0, 0, 0, 0);
    step(32'h3333_3333, 32'h7000, 0, 0, 0, 0);
    step(32'h4444_4444, 32'hFFFF_FFFC, 0, 0, 0, 0);
    step(32'h5555_5555, 32'h2FFC, 0, 0, 0, 0);
    step(32'h6666_6666, 32'h6FFC, 0, 0, 0, 0);

    // delay slot then 3-cycle stall holds bd_d
    step(32'h0800_0010, 32'h3008, 0, 0, 1, 0);
    repeat (3) step(32'h7777_7777, 32'h300C, 1, 0, 0, 0);
    step(32'h8888_8888, 32'h3001, 0, 0, 1, 0);  // faulting slot keeps bd

    // flush beats stall, then the same fetch loads
    step(32'h0000_4180, 32'h4180, 1, 1, 0, 0);
    step(32'h0000_4180, 32'h4180, 0, 0, 0, 0);

    // eret held by stall, then exactly one bubble, then a normal load
    step(32'h9999_9999, 32'h4184, 1, 0, 0, 1);
    step(32'h9999_9999, 32'h4184, 1, 0, 0, 1);
    step(32'h9999_9999, 32'h4184, 0, 0, 0, 1);
    step(32'hAAAA_AAAA, 32'h4188, 0, 0, 0, 0);
    // owed annul cleared by flush
    step(32'hBBBB_BBBB, 32'h418C, 1, 0, 0, 1);
    step(32'hBBBB_BBBB, 32'h418C, 0, 1, 0, 0);
    step(32'hCCCC_CCCC, 32'h4190, 0, 0, 0, 0);

    async_reset();
    step(32'hDDDD_DDDD, 32'h5000, 0, 0, 0, 0);

    for (int n = 0; n < 400; n++) begin
      sel = $urandom_range(0, 9);
      case (sel)
        0:       pc = $urandom();
        1:       pc = BASE + ($urandom_range(0, 4095) * 4) + $urandom_range(1, 3);
        2:       pc = $urandom_range(0, 32'h2FFC);
        3:       pc = 32'h7000 + $urandom_range(0, 1000) * 4;
        4:       pc = 32'hFFFF_FFFC;
        default: pc = BASE + $urandom_range(0, 4095) * 4;
      endcase
      ins = $urandom();
      step(ins, pc, $urandom_range(0, 3) == 0, $urandom_range(0, 9) == 0,
           $urandom_range(0, 3) == 0, $urandom_range(0, 7) == 0);
      if (n == 200) async_reset();
    end

    repeat (3) @(negedge clk);
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending, want 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
